// File: rtl/sobel_window_gen.sv
// Sobel input stage: turns a raster pixel stream into 3x3 neighbourhood windows
// using two line buffers and a 3x3 shift window, one window per interior pixel.

package sobel_config_pkg;
  localparam int unsigned IMAGE_ROW_SIZE    = 5;
  localparam int unsigned IMAGE_COLUMN_SIZE = 5;
  localparam int unsigned PIXEL_WIDTH       = 8;
  localparam int unsigned ROW_W             = $clog2(IMAGE_ROW_SIZE);
  localparam int unsigned COL_W             = $clog2(IMAGE_COLUMN_SIZE);

  // [r][c] flattens so element k = r*3+c lands at bits [k*PIXEL_WIDTH +: PIXEL_WIDTH]
  typedef logic [2:0][2:0][PIXEL_WIDTH-1:0] window_t;

  typedef struct packed {
    window_t          window;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             last;
  } win_payload_t;
endpackage

module sobel_window_gen
  import sobel_config_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [PIXEL_WIDTH-1:0]   in_pixel_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [9*PIXEL_WIDTH-1:0] out_window_o,
  output logic [ROW_W-1:0]         out_row_o,
  output logic [COL_W-1:0]         out_col_o,
  output logic                     out_last_o
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_ROW_SIZE - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_COLUMN_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

  typedef logic [IMAGE_COLUMN_SIZE-1:0][PIXEL_WIDTH-1:0] line_t;

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  line_t            lb1_q, lb1_d;
  line_t            lb2_q, lb2_d;
  window_t          win_q, win_d;
  logic             out_valid_q, out_valid_d;
  win_payload_t     out_q, out_d;
  logic             accept;
  logic             emit;

  // Stalled output window blocks intake so nothing is overwritten.
  assign in_ready_o = !out_valid_q || out_ready_i;

  // Counters, line buffers, shift window and output register next state.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    lb1_d       = lb1_q;
    lb2_d       = lb2_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    accept      = in_valid_i && in_ready_o;
    emit        = 1'b0;

    if (accept) begin
      lb2_d[col_q] = lb1_q[col_q];
      lb1_d[col_q] = in_pixel_i;

      win_d[0][0] = win_q[0][1];
      win_d[0][1] = win_q[0][2];
      win_d[0][2] = lb2_q[col_q];
      win_d[1][0] = win_q[1][1];
      win_d[1][1] = win_q[1][2];
      win_d[1][2] = lb1_q[col_q];
      win_d[2][0] = win_q[2][1];
      win_d[2][1] = win_q[2][2];
      win_d[2][2] = in_pixel_i;

      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end

      // Only interior centres produce a window; col>=2 keeps row wraps out.
      emit = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    end

    if (emit) begin
      out_valid_d  = 1'b1;
      out_d.window = win_d;
      out_d.row    = row_q - ROW_W'(1);
      out_d.col    = col_q - COL_W'(1);
      out_d.last   = (row_q == LAST_ROW) && (col_q == LAST_COL);
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q       <= '0;
      col_q       <= '0;
      lb1_q       <= '0;
      lb2_q       <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      lb1_q       <= lb1_d;
      lb2_q       <= lb2_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_window_o = out_q.window;
  assign out_row_o    = out_q.row;
  assign out_col_o    = out_q.col;
  assign out_last_o   = out_q.last;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: a frame-array model queues expected
// windows per accepted pixel; a negedge monitor pops and compares on handshake.

module tb_sobel_window_gen;
  import sobel_config_pkg::*;

  localparam int R  = IMAGE_ROW_SIZE;
  localparam int C  = IMAGE_COLUMN_SIZE;
  localparam int PW = PIXEL_WIDTH;
  localparam int WW = 9 * PIXEL_WIDTH;
  localparam int WIN_PER_FRAME = (R - 2) * (C - 2);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [PW-1:0]     in_pixel;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WW-1:0]     out_window;
  logic [ROW_W-1:0]  out_row;
  logic [COL_W-1:0]  out_col;
  logic              out_last;

  always #5 clk = ~clk;

  sobel_window_gen dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_pixel_i  (in_pixel),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_window_o(out_window),
    .out_row_o   (out_row),
    .out_col_o   (out_col),
    .out_last_o  (out_last)
  );

  typedef struct {
    logic [WW-1:0] win;
    int            row;
    int            col;
    bit            last;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_win = 0;
  int   pix_cnt = 0;
  int   img[R*C];
  int   ready_mode = 0;
  logic manual_ready = 1'b1;
  logic [WW-1:0] exp0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: frame stored as a flat array, window cut straight from it.
  task automatic model_accept(input int p);
    int idx = pix_cnt % (R * C);
    int r = idx / C;
    int c = idx % C;
    exp_t e;
    img[idx] = p;
    if (r >= 2 && c >= 2) begin
      e.win = '0;
      for (int k = 0; k < 9; k++)
        e.win[k*PW +: PW] = PW'(img[(r - 2 + k / 3) * C + (c - 2 + k % 3)]);
      e.row  = r - 1;
      e.col  = c - 1;
      e.last = (r == R - 1) && (c == C - 1);
      sb_q.push_back(e);
    end
    pix_cnt++;
  endtask

  // Out-ready driver: always 1, random, or test-controlled.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(1) == 1);
      default: out_ready = manual_ready;
    endcase
  end

  logic [WW-1:0]    snap_win;
  logic [ROW_W-1:0] snap_row;
  logic [COL_W-1:0] snap_col;
  logic             snap_last;
  bit               prev_stall = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall)
        chk("hold", 128'({out_valid, out_window, out_row, out_col, out_last}),
            128'({1'b1, snap_win, snap_row, snap_col, snap_last}));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_window: got row=%0d col=%0d want none", out_row, out_col);
        end else begin
          e = sb_q.pop_front();
          chk("window", 128'(out_window), 128'(e.win));
          chk("row", 128'(out_row), 128'(e.row));
          chk("col", 128'(out_col), 128'(e.col));
          chk("last", 128'(out_last), 128'(e.last));
        end
        n_win++;
      end
      prev_stall = out_valid && !out_ready;
      snap_win   = out_window;
      snap_row   = out_row;
      snap_col   = out_col;
      snap_last  = out_last;
    end
  end

  task automatic push_pixel(input int p, input int bubble_pct);
    int guard = 0;
    bit done = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      if (int'($urandom_range(99)) < bubble_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_pixel = PW'(p);
        @(negedge clk);
        if (in_ready) begin
          done = 1;
          model_accept(p);
        end
      end
      guard++;
      if (!done && guard > 1000) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got no accept want accept of pixel %0d", p);
        done = 1;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit rnd, input int bubble_pct);
    for (int i = 0; i < R * C; i++)
      push_pixel(rnd ? int'($urandom_range(255)) : base + i, bubble_pct);
  endtask

  task automatic drain(input int want, input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain: got %0d pending want 0", name, sb_q.size());
    end
    repeat (5) @(negedge clk);
    chk(name, 128'(n_win), 128'(want));
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, 128'(out_valid), 128'(0));
    chk({name, "_window"}, 128'(out_window), 128'(0));
    chk({name, "_rowcol"}, 128'({out_row, out_col}), 128'(0));
    chk({name, "_last"}, 128'(out_last), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 9; k++) exp0[k*PW +: PW] = PW'((k / 3) * C + k % 3);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    rst_n = 1'b1;

    // Single frame with latency and no-early-output checks.
    ready_mode = 0;
    n_win = 0;
    for (int i = 0; i < R * C; i++) begin
      push_pixel(i, 0);
      if (i <= 12) chk("no_early_out", 128'(out_valid), 128'(0));
      if (i == 12) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_valid", 128'(out_valid), 128'(1));
        chk("latency_centre", 128'({out_row, out_col}), 128'({ROW_W'(1), COL_W'(1)}));
        chk("first_window", 128'(out_window), 128'(exp0));
      end
    end
    idle();
    drain(WIN_PER_FRAME, "frame1_count");

    // Backpressure on the first window.
    ready_mode = 2;
    manual_ready = 1'b0;
    n_win = 0;
    fork
      send_frame(0, 0, 0);
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 200);
        chk("bp_seen", 128'(out_valid), 128'(1));
        repeat (4) begin
          chk("bp_in_ready", 128'(in_ready), 128'(0));
          chk("bp_window", 128'(out_window), 128'(exp0));
          @(negedge clk);
        end
        manual_ready = 1'b1;
      end
    join
    idle();
    drain(WIN_PER_FRAME, "bp_count");

    // Random pixels, input bubbles and random downstream ready.
    ready_mode = 1;
    n_win = 0;
    send_frame(0, 1, 50);
    send_frame(0, 1, 50);
    idle();
    drain(2 * WIN_PER_FRAME, "random_count");

    // Back-to-back frames.
    ready_mode = 0;
    n_win = 0;
    send_frame(0, 0, 0);
    send_frame(100, 0, 0);
    idle();
    drain(2 * WIN_PER_FRAME, "b2b_count");

    // Reset mid-frame with a stalled window held at the output.
    ready_mode = 2;
    manual_ready = 1'b0;
    for (int i = 0; i < 13; i++) push_pixel(200 + i, 0);
    idle();
    repeat (2) @(negedge clk);
    chk("pre_reset_held", 128'(out_valid), 128'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    sb_q.delete();
    pix_cnt = 0;
    ready_mode = 0;
    manual_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_win = 0;
    send_frame(0, 0, 0);
    idle();
    drain(WIN_PER_FRAME, "post_reset_count");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
